// File: rtl/diffusion_layer_seq.sv
// Iterative Ascon linear diffusion layer (p_L) with a valid/ready handshake on both sides.
// Words are diffused in place, one per CALC cycle (ROWS_PER_CYCLE=1) or all at once (=5).
package diffusion_layer_seq_pkg;
   typedef logic [4:0][63:0] t_state_array;
endpackage

module diffusion_layer_seq
   import diffusion_layer_seq_pkg::*;
#(
   parameter int ROWS_PER_CYCLE = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  t_state_array i_state,
   input  logic         i_valid,
   output logic         o_ready,
   output t_state_array o_state,
   output logic         o_valid,
   input  logic         i_ready
);

   generate
      if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 5) begin : g_bad_rows
         $fatal(1, "diffusion_layer_seq: ROWS_PER_CYCLE must be 1 or 5");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t       state_q, state_d;
   t_state_array data_q, data_d;
   logic [2:0]   cnt_q, cnt_d;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [63:0] diffuse(input logic [63:0] x, input logic [2:0] k);
      case (k)
         3'd0:    return x ^ rotr(x, 19) ^ rotr(x, 28);
         3'd1:    return x ^ rotr(x, 61) ^ rotr(x, 39);
         3'd2:    return x ^ rotr(x, 1)  ^ rotr(x, 6);
         3'd3:    return x ^ rotr(x, 10) ^ rotr(x, 17);
         3'd4:    return x ^ rotr(x, 7)  ^ rotr(x, 41);
         default: return x;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               data_d  = i_state;
               cnt_d   = 3'd0;
               state_d = CALC;
            end
         end
         CALC: begin
            // cnt selects the single word to update when serialised
            for (int k = 0; k < 5; k++) begin
               if (ROWS_PER_CYCLE == 5 || cnt_q == 3'(k)) begin
                  data_d[k] = diffuse(data_q[k], 3'(k));
               end
            end
            if (ROWS_PER_CYCLE == 5 || cnt_q == 3'd4) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign o_state = data_q;

endmodule

// File: tb/tb_diffusion_layer_seq.sv
// Directed bench for diffusion_layer_seq: one instance per legal ROWS_PER_CYCLE,
// table-driven vectors plus backpressure, mid-operation reset and streaming sequences.
module tb_diffusion_layer_seq;
   import diffusion_layer_seq_pkg::*;

   typedef struct {
      string        name;
      t_state_array in;
      t_state_array exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst  [2];
   logic         vld  [2];
   logic         rdy  [2];
   logic         ordy [2];
   logic         ovld [2];
   t_state_array sin  [2];
   t_state_array sout [2];

   int total  = 0;
   int passed = 0;
   vec_t vecs [5];

   always #5 clk = ~clk;

   diffusion_layer_seq #(.ROWS_PER_CYCLE(1)) dut1 (
      .i_clk(clk), .i_rst(rst[0]), .i_state(sin[0]), .i_valid(vld[0]),
      .o_ready(ordy[0]), .o_state(sout[0]), .o_valid(ovld[0]), .i_ready(rdy[0])
   );

   diffusion_layer_seq #(.ROWS_PER_CYCLE(5)) dut5 (
      .i_clk(clk), .i_rst(rst[1]), .i_state(sin[1]), .i_valid(vld[1]),
      .o_ready(ordy[1]), .o_state(sout[1]), .o_valid(ovld[1]), .i_ready(rdy[1])
   );

   function automatic int lat(input int d);
      return (d == 0) ? 5 : 1;
   endfunction

   task automatic chk(input string nm, input int d, input logic [319:0] act, input logic [319:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
   endtask

   task automatic run_vec(input int d, input vec_t v);
      int cyc;
      chk({v.name, " ready before accept"}, d, ordy[d], 1);
      vld[d] = 1'b1;
      sin[d] = v.in;
      @(negedge clk);
      vld[d] = 1'b0;
      sin[d] = ~v.in;
      cyc = 0;
      while (!ovld[d] && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({v.name, " latency"}, d, cyc, lat(d));
      chk({v.name, " state"}, d, sout[d], v.exp);
   endtask

   task automatic release_out(input int d);
      rdy[d] = 1'b1;
      @(negedge clk);
      rdy[d] = 1'b0;
      chk("release ready", d, ordy[d], 1);
      chk("release valid", d, ovld[d], 0);
   endtask

   initial begin
      vecs[0].name = "single-bit";
      vecs[0].in   = {5{64'h0000_0000_0000_0001}};
      vecs[0].exp  = {64'h0200_0000_0080_0001, 64'h0040_8000_0000_0001, 64'h8400_0000_0000_0001,
                      64'h0000_0000_0200_0009, 64'h0000_2010_0000_0001};
      vecs[1].name = "zero";
      vecs[1].in   = '0;
      vecs[1].exp  = '0;
      vecs[2].name = "all-ones";
      vecs[2].in   = '1;
      vecs[2].exp  = '1;
      vecs[3].name = "top-bit";
      vecs[3].in   = {5{64'h8000_0000_0000_0000}};
      vecs[3].exp  = {64'h8100_0000_0040_0000, 64'h8020_4000_0000_0000, 64'hC200_0000_0000_0000,
                      64'h8000_0000_0100_0004, 64'h8000_1008_0000_0000};
      vecs[4].name = "mixed-words";
      vecs[4].in   = {64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                      64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
      vecs[4].exp  = {64'h0200_0000_0080_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                      64'h8000_0000_0100_0004, 64'h0000_2010_0000_0001};

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         vld[d] = 1'b0;
         rdy[d] = 1'b0;
         sin[d] = '1;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset ready", d, ordy[d], 1);
         chk("reset valid", d, ovld[d], 0);
         chk("reset state", d, sout[d], '0);
         rst[d] = 1'b0;
      end

      for (int d = 0; d < 2; d++) begin
         // Directed vectors.
         for (int i = 0; i < 5; i++) begin
            run_vec(d, vecs[i]);
            release_out(d);
         end

         // Backpressure: hold DONE while inputs churn.
         run_vec(d, vecs[0]);
         for (int j = 0; j < 10; j++) begin
            vld[d] = j[0];
            sin[d] = {10{$urandom()}};
            @(negedge clk);
            chk("backpressure valid", d, ovld[d], 1);
            chk("backpressure ready", d, ordy[d], 0);
            chk("backpressure state", d, sout[d], vecs[0].exp);
         end
         vld[d] = 1'b0;
         release_out(d);

         // Reset while CALC is in progress.
         begin
            logic seen;
            seen = 1'b0;
            vld[d] = 1'b1;
            sin[d] = vecs[0].in;
            @(negedge clk);
            vld[d] = 1'b0;
            if (d == 0) begin
               repeat (2) @(negedge clk);
               seen = seen | ovld[d];
            end
            rst[d] = 1'b1;
            @(negedge clk);
            rst[d] = 1'b0;
            chk("midreset ready", d, ordy[d], 1);
            chk("midreset state", d, sout[d], '0);
            for (int j = 0; j < 8; j++) begin
               seen = seen | ovld[d];
               @(negedge clk);
            end
            chk("midreset valid never rose", d, seen, 0);
         end
         run_vec(d, vecs[4]);
         release_out(d);

         // Streaming with both handshakes held high.
         begin
            int  rises [3];
            int  nr;
            logic prev;
            nr   = 0;
            prev = 1'b0;
            vld[d] = 1'b1;
            rdy[d] = 1'b1;
            sin[d] = vecs[3].in;
            for (int c = 0; c < 30; c++) begin
               @(negedge clk);
               if (ovld[d] && !prev && nr < 3) begin
                  rises[nr] = c;
                  nr++;
                  chk("stream state", d, sout[d], vecs[3].exp);
               end
               prev = ovld[d];
            end
            vld[d] = 1'b0;
            chk("stream output count", d, nr, 3);
            if (nr == 3) begin
               chk("stream interval 1", d, rises[1] - rises[0], (d == 0) ? 7 : 3);
               chk("stream interval 2", d, rises[2] - rises[1], (d == 0) ? 7 : 3);
            end
            repeat (8) @(negedge clk);
            rdy[d] = 1'b0;
            chk("stream drained ready", d, ordy[d], 1);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
